// File: rtl/pipelined_cla_adder_pkg.sv
// Shared definitions for the pipelined carry-lookahead adder/subtractor.
// Holds the op encoding and the per-stage control record.
package adder_pkg;

  localparam logic OP_ADD = 1'b0;
  localparam logic OP_SUB = 1'b1;

  // Width-independent part of a pipeline stage record; operand/sum/tag
  // fields are appended in the module where WIDTH and TAG_W are known.
  typedef struct packed {
    logic valid;
    logic op;
    logic carry;
    logic c_msb;
  } stage_ctl_t;

endpackage

// File: rtl/pipelined_cla_adder_if.sv
// Operand/result handshake bundle for pipelined_cla_adder.
// slave = adder side, master = producer/consumer side.
interface pipelined_cla_adder_if #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned TAG_W = 4
);
  logic             in_valid;
  logic             in_ready;
  logic             in_op;
  logic [WIDTH-1:0] in_a;
  logic [WIDTH-1:0] in_b;
  logic             in_cin;
  logic [TAG_W-1:0] in_tag;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_sum;
  logic             out_cout;
  logic             out_ovf;
  logic [TAG_W-1:0] out_tag;

  modport slave (
    input  in_valid, in_op, in_a, in_b, in_cin, in_tag, out_ready,
    output in_ready, out_valid, out_sum, out_cout, out_ovf, out_tag
  );

  modport master (
    output in_valid, in_op, in_a, in_b, in_cin, in_tag, out_ready,
    input  in_ready, out_valid, out_sum, out_cout, out_ovf, out_tag
  );
endinterface

// File: rtl/cla_segment.sv
// Combinational SEG-bit adder built from 4-bit lookahead groups.
// Reports carry out and the carry into the segment MSB.
module cla_segment #(
  parameter int unsigned SEG = 8
) (
  input  logic [SEG-1:0] a,
  input  logic [SEG-1:0] b,
  input  logic           cin,
  output logic [SEG-1:0] sum,
  output logic           cout,
  output logic           c_msb
);
  localparam int unsigned NG = SEG / 4;

  logic [SEG-1:0] g, p, c;
  logic [NG-1:0]  gg, gp;
  logic [NG:0]    gc;

  assign g = a & b;
  assign p = a ^ b;

  always_comb begin
    gg = '0;
    gp = '0;
    gc = '0;
    c  = '0;
    for (int unsigned k = 0; k < NG; k++) begin
      gg[k] = g[4*k+3] | (p[4*k+3] & g[4*k+2]) | (p[4*k+3] & p[4*k+2] & g[4*k+1])
            | (p[4*k+3] & p[4*k+2] & p[4*k+1] & g[4*k]);
      gp[k] = &p[4*k +: 4];
    end
    gc[0] = cin;
    for (int unsigned k = 0; k < NG; k++) begin
      gc[k+1] = gg[k] | (gp[k] & gc[k]);
    end
    // Bit carries inside each group are expanded directly from the group carry-in.
    for (int unsigned k = 0; k < NG; k++) begin
      c[4*k]   = gc[k];
      c[4*k+1] = g[4*k] | (p[4*k] & gc[k]);
      c[4*k+2] = g[4*k+1] | (p[4*k+1] & g[4*k]) | (p[4*k+1] & p[4*k] & gc[k]);
      c[4*k+3] = g[4*k+2] | (p[4*k+2] & g[4*k+1]) | (p[4*k+2] & p[4*k+1] & g[4*k])
               | (p[4*k+2] & p[4*k+1] & p[4*k] & gc[k]);
    end
  end

  assign sum   = p ^ c;
  assign cout  = gc[NG];
  assign c_msb = c[SEG-1];
endmodule

// File: rtl/pipelined_cla_adder.sv
// Pipelined CLA adder/subtractor: one SEG-bit segment resolved per stage,
// valid/ready flow control with bubble collapse on every stage.
module pipelined_cla_adder
  import adder_pkg::*;
#(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned SEG   = 8,
  parameter int unsigned TAG_W = 4
) (
  input logic                 clk,
  input logic                 rst_n,
  pipelined_cla_adder_if.slave bus
);
  localparam int unsigned STAGES = WIDTH / SEG;

  if (WIDTH % SEG != 0) begin : g_chk_width
    $error("WIDTH must be a multiple of SEG");
  end
  if (SEG % 4 != 0) begin : g_chk_seg
    $error("SEG must be a multiple of 4");
  end
  if (STAGES < 1) begin : g_chk_stages
    $error("at least one stage required");
  end

  // x: resolved sum bits below the current segment, operand a above it.
  // y: operand b, already inverted for subtraction.
  typedef struct packed {
    stage_ctl_t       ctl;
    logic [WIDTH-1:0] x;
    logic [WIDTH-1:0] y;
    logic [TAG_W-1:0] tag;
  } stage_t;

  stage_t             st  [STAGES];
  stage_t             nxt [STAGES];
  logic [STAGES-1:0]  adv;

  always_comb begin
    adv = '0;
    adv[STAGES-1] = !st[STAGES-1].ctl.valid || bus.out_ready;
    for (int unsigned i = 1; i < STAGES; i++) begin
      adv[STAGES-1-i] = !st[STAGES-1-i].ctl.valid || adv[STAGES-i];
    end
  end

  for (genvar s = 0; s < STAGES; s++) begin : g_stage
    stage_t         src;
    logic [SEG-1:0] seg_sum;
    logic           seg_cout;
    logic           seg_cmsb;

    if (s == 0) begin : g_entry
      always_comb begin
        src           = '0;
        src.ctl.valid = bus.in_valid;
        src.ctl.op    = bus.in_op;
        src.ctl.carry = (bus.in_op == OP_SUB) ? ~bus.in_cin : bus.in_cin;
        src.x         = bus.in_a;
        src.y         = (bus.in_op == OP_SUB) ? ~bus.in_b : bus.in_b;
        src.tag       = bus.in_tag;
      end
    end else begin : g_chain
      assign src = st[s-1];
    end

    cla_segment #(.SEG(SEG)) u_seg (
      .a     (src.x[s*SEG +: SEG]),
      .b     (src.y[s*SEG +: SEG]),
      .cin   (src.ctl.carry),
      .sum   (seg_sum),
      .cout  (seg_cout),
      .c_msb (seg_cmsb)
    );

    always_comb begin
      nxt[s]                   = src;
      nxt[s].x[s*SEG +: SEG]   = seg_sum;
      nxt[s].ctl.carry         = seg_cout;
      nxt[s].ctl.c_msb         = seg_cmsb;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned s = 0; s < STAGES; s++) st[s] <= '0;
    end else begin
      for (int unsigned s = 0; s < STAGES; s++) begin
        if (adv[s]) st[s] <= nxt[s];
      end
    end
  end

  assign bus.in_ready  = adv[0];
  assign bus.out_valid = st[STAGES-1].ctl.valid;
  assign bus.out_sum   = st[STAGES-1].x;
  assign bus.out_cout  = st[STAGES-1].ctl.carry;
  assign bus.out_ovf   = st[STAGES-1].ctl.carry ^ st[STAGES-1].ctl.c_msb;
  assign bus.out_tag   = st[STAGES-1].tag;
endmodule

// File: tb/tb_pipelined_cla_adder.sv
// Directed-vector bench for pipelined_cla_adder (WIDTH=32, SEG=8).
// A negedge monitor checks every popped result against a queue of expectations.
module tb_pipelined_cla_adder;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   total = 0;
  int   bad = 0;
  int   pops = 0;
  logic [37:0] expq [$];

  pipelined_cla_adder_if #(.WIDTH(32), .TAG_W(4)) bus ();

  pipelined_cla_adder #(.WIDTH(32), .SEG(8), .TAG_W(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [37:0] model(input logic op, input logic [31:0] a, input logic [31:0] b,
                                        input logic cin, input logic [3:0] tag);
    logic [31:0] bb;
    logic        c0;
    logic [32:0] full;
    logic [31:0] low;
    bb   = op ? ~b : b;
    c0   = op ? ~cin : cin;
    full = {1'b0, a} + {1'b0, bb} + 33'(c0);
    low  = {1'b0, a[30:0]} + {1'b0, bb[30:0]} + 32'(c0);
    return {full[31:0], full[32], full[32] ^ low[31], tag};
  endfunction

  always @(negedge clk) begin
    if (rst_n && bus.out_valid && bus.out_ready) begin
      pops++;
      if (expq.size() == 0) check("unexpected_result", 64'd1, 64'd0);
      else check("result", {bus.out_sum, bus.out_cout, bus.out_ovf, bus.out_tag}, expq.pop_front());
    end
  end

  task automatic drive(input logic op, input logic [31:0] a, input logic [31:0] b,
                       input logic cin, input logic [3:0] tag, input logic [37:0] e);
    bus.in_op    = op;
    bus.in_a     = a;
    bus.in_b     = b;
    bus.in_cin   = cin;
    bus.in_tag   = tag;
    bus.in_valid = 1'b1;
    expq.push_back(e);
  endtask

  task automatic wait_accept(input string tag);
    bit done = 0;
    for (int i = 0; i < 50 && !done; i++) begin
      @(negedge clk);
      if (bus.in_ready) begin
        @(posedge clk);
        #1;
        done = 1;
      end
    end
    bus.in_valid = 1'b0;
    check(tag, 64'(done), 64'd1);
  endtask

  task automatic push(input logic op, input logic [31:0] a, input logic [31:0] b,
                      input logic cin, input logic [3:0] tag, input logic [37:0] e);
    drive(op, a, b, cin, tag, e);
    wait_accept("accept");
  endtask

  task automatic push_rand(input logic [3:0] tag);
    logic        op;
    logic [31:0] a, b;
    logic        cin;
    op  = 1'($urandom);
    a   = $urandom;
    b   = $urandom;
    cin = 1'($urandom);
    push(op, a, b, cin, tag, model(op, a, b, cin, tag));
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic wait_drain();
    bit done = 0;
    for (int i = 0; i < 200 && !done; i++) begin
      tick(1);
      if (expq.size() == 0 && !bus.out_valid) done = 1;
    end
    check("drain", 64'(expq.size()), 64'd0);
  endtask

  initial begin
    int   t0;
    int   p0;
    logic [31:0] held;

    bus.in_valid  = 1'b0;
    bus.in_op     = 1'b0;
    bus.in_a      = '0;
    bus.in_b      = '0;
    bus.in_cin    = 1'b0;
    bus.in_tag    = '0;
    bus.out_ready = 1'b1;

    // reset state
    tick(2);
    check("rst_out_valid", 64'(bus.out_valid), 64'd0);
    check("rst_in_ready",  64'(bus.in_ready),  64'd1);
    check("rst_outputs", {bus.out_sum, bus.out_cout, bus.out_ovf, bus.out_tag}, 64'd0);
    rst_n = 1'b1;
    tick(1);

    // latency and carry across all segments
    push(1'b0, 32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 4'h1, {32'h0000_0000, 1'b1, 1'b0, 4'h1});
    tick(2);
    check("latency_early", 64'(bus.out_valid), 64'd0);
    tick(1);
    check("latency_n4", 64'(bus.out_valid), 64'd1);
    wait_drain();

    // directed corner vectors back to back
    push(1'b0, 32'h7FFF_FFFF, 32'h0000_0000, 1'b1, 4'h2, {32'h8000_0000, 1'b0, 1'b1, 4'h2});
    push(1'b1, 32'h0000_0005, 32'h0000_0007, 1'b0, 4'h3, {32'hFFFF_FFFE, 1'b0, 1'b0, 4'h3});
    push(1'b1, 32'h8000_0000, 32'h0000_0001, 1'b0, 4'h4, {32'h7FFF_FFFF, 1'b1, 1'b1, 4'h4});
    push(1'b1, 32'h0000_000A, 32'h0000_0003, 1'b1, 4'h5, {32'h0000_0006, 1'b1, 1'b0, 4'h5});
    push(1'b0, 32'h00FF_FFFF, 32'h0000_0001, 1'b0, 4'h6, {32'h0100_0000, 1'b0, 1'b0, 4'h6});
    push(1'b0, 32'h8000_0000, 32'h8000_0000, 1'b0, 4'h7, {32'h0000_0000, 1'b1, 1'b1, 4'h7});
    wait_drain();

    // back-to-back throughput
    p0 = pops;
    t0 = int'($time);
    for (int i = 0; i < 100; i++) push_rand(4'(i));
    check("throughput_cycles", 64'((int'($time) - t0) / 10), 64'd100);
    wait_drain();
    check("throughput_count", 64'(pops - p0), 64'd100);

    // backpressure: fill, hold, then simultaneous pop and push
    bus.out_ready = 1'b0;
    push(1'b0, 32'd1, 32'd2, 1'b0, 4'h1, {32'd3, 1'b0, 1'b0, 4'h1});
    push(1'b0, 32'd10, 32'd20, 1'b0, 4'h2, {32'd30, 1'b0, 1'b0, 4'h2});
    push(1'b1, 32'd100, 32'd1, 1'b0, 4'h3, {32'd99, 1'b1, 1'b0, 4'h3});
    push(1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 4'h4, {32'hFFFF_FFFF, 1'b1, 1'b0, 4'h4});
    drive(1'b0, 32'd5, 32'd6, 1'b0, 4'h5, {32'd11, 1'b0, 1'b0, 4'h5});
    #1;
    check("full_in_ready", 64'(bus.in_ready), 64'd0);
    held = bus.out_sum;
    tick(2);
    check("stall_in_ready", 64'(bus.in_ready), 64'd0);
    check("stall_tag", 64'(bus.out_tag), 64'h1);
    check("stall_hold", 64'(bus.out_sum), 64'(held));
    check("stall_sum", 64'(bus.out_sum), 64'd3);
    bus.out_ready = 1'b1;
    #1;
    check("ready_comb", 64'(bus.in_ready), 64'd1);
    p0 = pops;
    wait_accept("accept_while_full");
    check("pop_with_push", 64'(pops - p0), 64'd1);
    check("after_pop_tag", 64'(bus.out_tag), 64'h2);
    push(1'b1, 32'd0, 32'd1, 1'b0, 4'h6, {32'hFFFF_FFFF, 1'b0, 1'b0, 4'h6});
    wait_drain();

    // bubble collapse
    bus.out_ready = 1'b0;
    push(1'b0, 32'h1234_5678, 32'h1111_1111, 1'b0, 4'hA, {32'h2345_6789, 1'b0, 1'b0, 4'hA});
    tick(2);
    push(1'b1, 32'd50, 32'd8, 1'b1, 4'hB, {32'd41, 1'b1, 1'b0, 4'hB});
    tick(2);
    check("bubble_in_ready", 64'(bus.in_ready), 64'd1);
    check("bubble_out_tag", 64'(bus.out_tag), 64'hA);
    push(1'b0, 32'd7, 32'd7, 1'b0, 4'hC, {32'd14, 1'b0, 1'b0, 4'hC});
    push(1'b0, 32'd9, 32'd9, 1'b1, 4'hD, {32'd19, 1'b0, 1'b0, 4'hD});
    check("bubble_full", 64'(bus.in_ready), 64'd0);
    bus.out_ready = 1'b1;
    wait_drain();

    // reset with operations in flight
    push_rand(4'h1);
    push_rand(4'h2);
    push_rand(4'h3);
    rst_n = 1'b0;
    expq.delete();
    #1;
    check("midrst_out_valid", 64'(bus.out_valid), 64'd0);
    check("midrst_outputs", {bus.out_sum, bus.out_cout, bus.out_ovf, bus.out_tag}, 64'd0);
    check("midrst_in_ready", 64'(bus.in_ready), 64'd1);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    p0 = pops;
    tick(6);
    check("no_stale", 64'(pops - p0), 64'd0);
    check("no_stale_valid", 64'(bus.out_valid), 64'd0);
    push(1'b1, 32'h0000_1000, 32'h0000_0001, 1'b0, 4'h9, {32'h0000_0FFF, 1'b1, 1'b0, 4'h9});
    tick(2);
    check("post_rst_early", 64'(bus.out_valid), 64'd0);
    tick(1);
    check("post_rst_valid", 64'(bus.out_valid), 64'd1);
    wait_drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end
endmodule
